// File: rtl/tri_solve.sv
// Triangular-system solver: forward or backward substitution on an N x N
// signed integer matrix, one multiply-accumulate per cycle, optional unit diagonal.
module tri_solve #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             upper,
  input  logic             unit_diag,
  input  logic [N*N*W-1:0] a_in,
  input  logic [N*W-1:0]   b_in,
  output logic             busy,
  output logic             done,
  output logic             err_div0,
  output logic [N*W-1:0]   x_out
);

  localparam int IW = $clog2(N + 1);
  localparam logic [IW-1:0] ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [2:0] {IDLE, INIT, MAC, WB, DONE} state_t;

  state_t state, state_next;

  logic [N*N*W-1:0]    a_r;
  logic [N*W-1:0]      b_r;
  logic [N*W-1:0]      x_r;
  logic                upper_r;
  logic                unit_r;
  logic signed [W-1:0] acc;
  logic [IW-1:0]       row;
  logic [IW-1:0]       col;

  logic signed [W-1:0] a_rk;
  logic signed [W-1:0] diag;
  logic signed [W-1:0] x_k;
  logic signed [W-1:0] prod;
  logic signed [W-1:0] wb_val;
  logic                no_terms;
  logic                last_term;
  logic                last_row;
  logic                div0_hit;

  function automatic logic signed [W-1:0] mat_elem(input logic [N*N*W-1:0] m,
                                                   input logic [IW-1:0] rr,
                                                   input logic [IW-1:0] cc);
    return m[(int'(rr) * N + int'(cc)) * W +: W];
  endfunction

  // Operand selection, loop-bound decode and the write-back value.
  always_comb begin
    a_rk      = mat_elem(a_r, row, col);
    diag      = mat_elem(a_r, row, row);
    x_k       = x_r[int'(col) * W +: W];
    prod      = a_rk * x_k;
    no_terms  = upper_r ? (row == LAST) : (row == ZERO);
    last_term = upper_r ? (col == LAST) : (col == row - ONE);
    last_row  = upper_r ? (row == ZERO) : (row == LAST);
    div0_hit  = 1'b0;
    if (unit_r) begin
      wb_val = acc;
    end else if (diag == {W{1'b0}}) begin
      wb_val   = {W{1'b0}};
      div0_hit = 1'b1;
    end else begin
      wb_val = acc / diag;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = INIT;
        else       state_next = IDLE;
      end
      INIT: begin
        if (no_terms) state_next = WB;
        else          state_next = MAC;
      end
      MAC: begin
        if (last_term) state_next = WB;
        else           state_next = MAC;
      end
      WB: begin
        if (last_row) state_next = DONE;
        else          state_next = INIT;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      x_r      <= '0;
      upper_r  <= 1'b0;
      unit_r   <= 1'b0;
      acc      <= '0;
      row      <= ZERO;
      col      <= ZERO;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_div0 <= 1'b0;
      x_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r      <= a_in;
            b_r      <= b_in;
            upper_r  <= upper;
            unit_r   <= unit_diag;
            x_r      <= '0;
            row      <= upper ? LAST : ZERO;
            busy     <= 1'b1;
            done     <= 1'b0;
            err_div0 <= 1'b0;
          end
        end
        INIT: begin
          acc <= b_r[int'(row) * W +: W];
          col <= upper_r ? row + ONE : ZERO;
        end
        MAC: begin
          acc <= acc - prod;
          col <= col + ONE;
        end
        WB: begin
          x_r[int'(row) * W +: W] <= wb_val;
          if (div0_hit) err_div0 <= 1'b1;
          // Backward mode wraps row past zero only after the final row.
          row <= upper_r ? row - ONE : row + ONE;
        end
        DONE: begin
          x_out <= x_r;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_solve.sv
// Directed self-checking bench for tri_solve (N=4 and N=2 builds).
module tb_tri_solve;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, upper, unit_diag;
  logic [511:0] a_in;
  logic [127:0] b_in;
  logic         busy, done, err_div0;
  logic [127:0] x_out;

  logic         start2;
  logic [127:0] a2;
  logic [63:0]  b2;
  logic         busy2, done2, err2;
  logic [63:0]  x2;

  int n_checks = 0;
  int n_err    = 0;
  int am [16];
  int bv [4];
  int ex [4];

  always #5 clk = ~clk;

  tri_solve #(.N(4), .W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .upper(upper), .unit_diag(unit_diag),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .err_div0(err_div0),
    .x_out(x_out)
  );

  tri_solve #(.N(2), .W(32)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .upper(1'b0), .unit_diag(1'b0),
    .a_in(a2), .b_in(b2), .busy(busy2), .done(done2), .err_div0(err2),
    .x_out(x2)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pack_a();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = am[i];
    return v;
  endfunction

  function automatic logic [127:0] pack4(input int q [4]);
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = q[i];
    return v;
  endfunction

  task automatic clear_data();
    for (int i = 0; i < 16; i++) am[i] = 0;
    for (int i = 0; i < 4; i++) begin
      bv[i] = 0;
      ex[i] = 0;
    end
  endtask

  // One solve: start sampled at edge 0, optional start pulses at edges 3 and 9.
  task automatic run(input string tag, input bit up, input bit ud, input bit pulse,
                     input bit exp_err);
    logic [127:0] prev;
    int done_edge;
    @(negedge clk);
    a_in = pack_a(); b_in = pack4(bv); upper = up; unit_diag = ud; start = 1'b1;
    prev = x_out;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = {16{32'h5A5A_0101}}; b_in = {4{32'h0000_0077}};
    upper = ~up; unit_diag = ~ud;
    check({tag, "_busy0"}, {127'd0, busy}, 128'd1);
    check({tag, "_done0"}, {127'd0, done}, 128'd0);
    done_edge = 0;
    for (int e = 1; e <= 40 && done_edge == 0; e++) begin
      if (pulse && (e == 3 || e == 9)) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (e == 5) check({tag, "_xhold"}, x_out, prev);
      if (done) done_edge = e;
    end
    check({tag, "_done_edge"}, 128'(done_edge), 128'd15);
    check({tag, "_x"}, x_out, pack4(ex));
    check({tag, "_err"}, {127'd0, err_div0}, {127'd0, exp_err});
    check({tag, "_busy_end"}, {127'd0, busy}, 128'd0);
  endtask

  initial begin
    int done_edge;
    rst = 1'b1; start = 1'b0; upper = 1'b0; unit_diag = 1'b0;
    a_in = '0; b_in = '0; start2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_err",  {127'd0, err_div0}, 128'd0);
    check("rst_x",    x_out, 128'd0);
    check("rst2_x",   {64'd0, x2}, 128'd0);
    @(negedge clk); rst = 1'b0;

    // Forward; (0,3) lies outside the lower triangle and must be ignored.
    clear_data();
    am[0] = 2; am[3] = 99; am[4] = 1; am[5] = 1;
    am[8] = 3; am[9] = 2; am[10] = 4;
    am[12] = 1; am[13] = 1; am[14] = 1; am[15] = 1;
    bv = '{4, 5, 28, 10}; ex = '{2, 3, 4, 1};
    run("fwd", 1'b0, 1'b0, 1'b0, 1'b0);

    // Backward; (3,0) lies outside the upper triangle.
    clear_data();
    am[0] = 1; am[1] = 2; am[5] = 1; am[6] = 1;
    am[10] = 1; am[11] = 3; am[15] = 2; am[12] = 77;
    bv = '{5, 5, 15, 8}; ex = '{1, 2, 3, 4};
    run("bwd", 1'b1, 1'b0, 1'b0, 1'b0);

    clear_data();
    am[4] = 3; bv = '{2, 7, 0, 0}; ex = '{2, 1, 0, 0};
    run("unit", 1'b0, 1'b1, 1'b0, 1'b0);
    ex = '{0, 0, 0, 0};
    run("div0", 1'b0, 1'b0, 1'b0, 1'b1);

    clear_data();
    am[0] = 2; am[4] = -1; am[5] = -2; am[10] = 1; am[15] = 1;
    bv = '{-7, -8, 0, 0}; ex = '{-3, 5, 0, 0};
    run("trunc", 1'b0, 1'b0, 1'b0, 1'b0);

    clear_data();
    am[0] = 2; am[4] = 1; am[5] = 1; am[8] = 3; am[9] = 2; am[10] = 4;
    am[12] = 1; am[13] = 1; am[14] = 1; am[15] = 1;
    bv = '{4, 5, 28, 10}; ex = '{2, 3, 4, 1};
    run("pulse", 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset sampled at edge 7 of a solve.
    @(negedge clk);
    a_in = pack_a(); b_in = pack4(bv); upper = 1'b0; unit_diag = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    check("mid_rst_done", {127'd0, done}, 128'd0);
    check("mid_rst_x",    x_out, 128'd0);
    run("after_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // N=2 build.
    @(negedge clk);
    a2 = '0; a2[0*32 +: 32] = 32'd1; a2[2*32 +: 32] = 32'd2; a2[3*32 +: 32] = 32'd1;
    b2 = {32'd8, 32'd3}; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    done_edge = 0;
    for (int e = 1; e <= 20 && done_edge == 0; e++) begin
      @(posedge clk); #1;
      if (done2) done_edge = e;
    end
    check("n2_done_edge", 128'(done_edge), 128'd6);
    check("n2_x", {64'd0, x2}, {64'd0, 32'd2, 32'd3});
    check("n2_err", {127'd0, err2}, 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
